// File: rtl/invsqrt_rr_scheduler_if.sv
// Requester-side bus of invsqrt_rr_scheduler: operand handshake plus one-hot result return.
// master = requester/consumer side, slave = scheduler side.
interface invsqrt_rr_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_stall;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [30:0]           rsp_data;

    modport master (
        output req_valid, req_data, rsp_stall,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, rsp_stall,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/invsqrt_rr_scheduler.sv
// Round-robin sharing of one invsqrt_pipeline among NUM_REQ requesters.
// A tag FIFO remembers the owner of each in-flight op so results are routed back in issue order.
module invsqrt_rr_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    invsqrt_rr_scheduler_if.slave        bus,
    input  logic                         drain_req,
    input  logic                         resume,
    output logic                         drain_done,
    output logic                         pipe_ce,
    output logic [31:0]                  pipe_din,
    output logic                         pipe_backprn,
    input  logic [30:0]                  pipe_dout,
    input  logic                         pipe_ready,
    output logic                         err_underflow
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_rr;
    logic [CW-1:0]        r_inflight;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [IDW-1:0]       r_tag [MAX_INFLIGHT];
    logic                 r_pipe_ce;
    logic [31:0]          r_pipe_din;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [30:0]          r_rsp_data;
    logic                 r_drain_done;
    logic                 r_err;

    logic                 w_issue_en;
    logic                 w_found;
    logic                 w_fire;
    logic                 w_pop;
    logic                 w_underflow;
    logic                 w_empty;
    logic [IDW-1:0]       w_gid;
    logic [IDW-1:0]       w_idx;
    logic [NUM_REQ-1:0]   w_grant;

    assign w_empty     = (r_inflight == '0);
    // rstn gates the combinational grant so req_ready reads 0 throughout reset
    assign w_issue_en  = rstn & (r_state == ST_RUN) & ~bus.rsp_stall
                       & (r_inflight < CW'(MAX_INFLIGHT));
    assign w_pop       = pipe_ready & ~bus.rsp_stall & ~w_empty;
    assign w_underflow = pipe_ready & ~bus.rsp_stall & w_empty;
    assign w_fire      = w_issue_en & w_found;

    // First requesting id strictly after the rr pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gid   = r_rr;
        w_idx   = '0;
        w_grant = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDW'((32'(r_rr) + k) % 32'(NUM_REQ));
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = w_idx;
            end
        end
        if (w_issue_en && w_found) begin
            w_grant[w_gid] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag[r_wr_ptr] <= w_gid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_RUN;
            r_rr         <= IDW'(NUM_REQ - 1);
            r_inflight   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pipe_ce    <= 1'b0;
            r_pipe_din   <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_drain_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pipe_ce    <= w_fire;
            r_rsp_valid  <= '0;
            r_drain_done <= 1'b0;

            if (w_fire) begin
                r_rr       <= w_gid;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_pipe_din <= bus.req_data[32*w_gid +: 32];
            end

            if (w_pop) begin
                r_rd_ptr                  <= r_rd_ptr + 1'b1;
                r_rsp_valid[r_tag[r_rd_ptr]] <= 1'b1;
                r_rsp_data                <= pipe_dout;
            end

            case ({w_fire, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            if (w_underflow) begin
                r_err <= 1'b1;
            end

            // pipe_ce==0 ensures the last issued op has actually entered the pipeline
            case (r_state)
                ST_RUN: begin
                    if (drain_req) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_empty && !r_pipe_ce) begin
                        r_state      <= ST_HALT;
                        r_drain_done <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign pipe_ce       = r_pipe_ce;
    assign pipe_din      = r_pipe_din;
    assign pipe_backprn  = ~bus.rsp_stall;
    assign drain_done    = r_drain_done;
    assign err_underflow = r_err;
endmodule

// File: tb/tb_invsqrt_rr_scheduler.sv
// Bench for invsqrt_rr_scheduler: behavioural pipeline + queue-based scheduler model,
// directed scenarios followed by randomized traffic with a mid-stream asynchronous reset.
module tb_invsqrt_rr_scheduler;
    localparam int N    = 4;
    localparam int MAXI = 16;
    localparam int LAT  = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    invsqrt_rr_scheduler_if #(.NUM_REQ(N)) bus ();

    logic        drain_req = 1'b0;
    logic        resume    = 1'b0;
    logic        drain_done;
    logic        pipe_ce;
    logic [31:0] pipe_din;
    logic        pipe_backprn;
    logic [30:0] pipe_dout  = '0;
    logic        pipe_ready = 1'b0;
    logic        err_underflow;

    invsqrt_rr_scheduler #(.NUM_REQ(N), .MAX_INFLIGHT(MAXI)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .drain_req    (drain_req),
        .resume       (resume),
        .drain_done   (drain_done),
        .pipe_ce      (pipe_ce),
        .pipe_din     (pipe_din),
        .pipe_backprn (pipe_backprn),
        .pipe_dout    (pipe_dout),
        .pipe_ready   (pipe_ready),
        .err_underflow(err_underflow)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // next-cycle stimulus
    logic [N-1:0] nx_valid = '0;
    logic [31:0]  nx_data [N];
    logic nx_stall = 1'b0, nx_drain = 1'b0, nx_resume = 1'b0, nx_rstn = 1'b0;
    bit   pl_hold = 1'b0, force_ready = 1'b0;

    // environment pipeline: results with remaining latency
    logic [30:0] pl_data[$];
    int          pl_cnt[$];

    // reference model
    int          m_st, m_last;
    int          m_id[$];
    logic [31:0] m_op[$];
    logic        m_ce, m_done, m_err;
    logic [31:0] m_din;
    logic [N-1:0] m_rv;
    logic [30:0] m_rd;

    // what was presented before the coming posedge
    logic [N-1:0] s_valid = '0;
    logic [31:0]  s_data [N];
    logic s_stall = 1'b0, s_drain = 1'b0, s_resume = 1'b0, s_pready = 1'b0, s_real = 1'b0, s_ce = 1'b0;
    logic [31:0] s_din = '0;
    int          s_gid = -1;

    logic [N-1:0] grant_seen[$];
    logic [N-1:0] rsp_seen[$];

    function automatic logic [30:0] pipe_fn(input logic [31:0] x);
        if (x == 32'h40800000) return 31'h3F000000;  // 1/sqrt(4.0) = 0.5
        return x[30:0] ^ 31'h2AAA5555;               // stand-in; only traceability matters
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h80000000;
            1:       return 32'h7FC00000;
            2:       return 32'h00000000;
            3:       return 32'hC0400000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_st = 0; m_last = N - 1;
        m_id.delete(); m_op.delete();
        m_ce = 1'b0; m_din = '0; m_rv = '0; m_rd = '0; m_done = 1'b0; m_err = 1'b0;
        pl_data.delete(); pl_cnt.delete();
    endtask

    task automatic commit();
        int   old_n;
        logic old_ce, pop, under, fire;
        if (!s_stall) begin
            if (s_real) begin
                void'(pl_data.pop_front());
                void'(pl_cnt.pop_front());
            end
            foreach (pl_cnt[i]) if (pl_cnt[i] > 0) pl_cnt[i]--;
        end
        if (s_ce) begin
            pl_data.push_back(pipe_fn(s_din));
            pl_cnt.push_back(LAT);
        end

        old_n  = m_id.size();
        old_ce = m_ce;
        fire   = (s_gid >= 0);
        pop    = s_pready && !s_stall && old_n > 0;
        under  = s_pready && !s_stall && old_n == 0;
        m_rv   = '0;
        if (pop) begin
            m_rv[m_id[0]] = 1'b1;
            m_rd = pipe_fn(m_op[0]);
            void'(m_id.pop_front());
            void'(m_op.pop_front());
        end
        if (under) m_err = 1'b1;
        if (fire) begin
            m_id.push_back(s_gid);
            m_op.push_back(s_data[s_gid]);
            m_last = s_gid;
            m_din  = s_data[s_gid];
        end
        m_ce   = fire;
        m_done = 1'b0;
        case (m_st)
            0: if (s_drain) m_st = 1;
            1: if (old_n == 0 && !old_ce) begin m_st = 2; m_done = 1'b1; end
            2: if (s_resume) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    task automatic cycle();
        int g;
        @(negedge clk);
        if (!rstn) model_reset();
        else commit();
        chk("pipe_ce",       32'(pipe_ce),        32'(m_ce));
        chk("pipe_din",      pipe_din,            m_din);
        chk("rsp_valid",     32'(bus.rsp_valid),  32'(m_rv));
        chk("rsp_data",      32'(bus.rsp_data),   32'(m_rd));
        chk("drain_done",    32'(drain_done),     32'(m_done));
        chk("err_underflow", 32'(err_underflow),  32'(m_err));
        if (bus.rsp_valid != '0) rsp_seen.push_back(bus.rsp_valid);

        rstn          = nx_rstn;
        bus.req_valid = nx_valid;
        for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = nx_data[i];
        bus.rsp_stall = nx_stall;
        drain_req     = nx_drain;
        resume        = nx_resume;
        s_real        = (pl_cnt.size() > 0) && (pl_cnt[0] == 0) && !pl_hold;
        pipe_ready    = s_real || force_ready;
        pipe_dout     = s_real ? pl_data[0] : 31'h1234567;
        #1;
        g = -1;
        if (rstn && m_st == 0 && !nx_stall && m_id.size() < MAXI) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (g < 0 && nx_valid[i]) g = i;
            end
        end
        chk("req_ready",    32'(bus.req_ready),  (g < 0) ? 32'd0 : (32'd1 << g));
        chk("pipe_backprn", 32'(pipe_backprn),   32'(!nx_stall));
        if (bus.req_ready != '0) grant_seen.push_back(bus.req_ready);

        s_valid  = nx_valid;
        for (int i = 0; i < N; i++) s_data[i] = nx_data[i];
        s_stall  = nx_stall;
        s_drain  = nx_drain;
        s_resume = nx_resume;
        s_pready = pipe_ready;
        s_ce     = pipe_ce;
        s_din    = pipe_din;
        s_gid    = g;
    endtask

    task automatic quiesce();
        bit ok;
        ok = 1'b0;
        nx_valid = '0; nx_stall = 1'b0; nx_drain = 1'b0; nx_resume = 1'b0;
        pl_hold = 1'b0; force_ready = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            cycle();
            ok = (m_id.size() == 0) && (pl_data.size() == 0) && !m_ce;
        end
        chk("quiesce", 32'(ok), 32'd1);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) nx_data[i] = rnd_op();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"},  32'(bus.req_ready), 32'd0);
        chk({tag, "_pipe_ce"},    32'(pipe_ce),       32'd0);
        chk({tag, "_pipe_din"},   pipe_din,           32'd0);
        chk({tag, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},   32'(bus.rsp_data),  32'd0);
        chk({tag, "_drain_done"}, 32'(drain_done),    32'd0);
        chk({tag, "_err"},        32'(err_underflow), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rr_exp [8];
        bit  got;
        int  lastid;
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) begin nx_data[i] = '0; s_data[i] = '0; end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_stall = 1'b0;
        model_reset();

        // reset values
        nx_rstn = 1'b0;
        nx_valid = 4'b1111;
        repeat (3) cycle();
        check_reset_values("rst");
        nx_valid = '0;
        nx_rstn  = 1'b1;
        cycle();

        // single op from req0: 4.0 -> 0.5
        nx_valid = 4'b0001;
        nx_data[0] = 32'h40800000;
        cycle();
        chk("t1_grant", 32'(bus.req_ready), 32'h1);
        nx_valid = '0;
        cycle();
        chk("t1_ce",  32'(pipe_ce), 32'h1);
        chk("t1_din", pipe_din,     32'h40800000);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            cycle();
            if (bus.rsp_valid != '0) begin
                got = 1'b1;
                chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
                chk("t1_rsp_data",  32'(bus.rsp_data),  32'h3F000000);
            end
        end
        chk("t1_rsp_seen", 32'(got), 32'd1);
        quiesce();

        // all requesters for 8 cycles: rr continues after req0
        grant_seen.delete(); rsp_seen.delete();
        nx_valid = '1;
        repeat (8) begin rand_data(); cycle(); end
        quiesce();
        chk("rr_grant_count", grant_seen.size(), 32'd8);
        chk("rr_rsp_count",   rsp_seen.size(),   32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_seen.size()) chk("rr_grant_order", 32'(grant_seen[i]), 32'(rr_exp[i]));
            if (i < rsp_seen.size())   chk("rr_rsp_order",   32'(rsp_seen[i]),   32'(rr_exp[i]));
        end

        // 5-cycle stall mid-stream
        grant_seen.delete(); rsp_seen.delete();
        nx_valid = '1;
        repeat (8) begin rand_data(); cycle(); end
        nx_stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            rand_data();
            cycle();
            chk("stall_backprn", 32'(pipe_backprn),   32'd0);
            chk("stall_ready",   32'(bus.req_ready),  32'd0);
            if (s > 0) chk("stall_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        nx_stall = 1'b0;
        repeat (4) begin rand_data(); cycle(); end
        quiesce();
        chk("stall_conserve", rsp_seen.size(), grant_seen.size());

        // fill to MAX_INFLIGHT with results held back
        grant_seen.delete();
        pl_hold  = 1'b1;
        nx_valid = '1;
        repeat (20) begin rand_data(); cycle(); end
        chk("full_grants", grant_seen.size(),   32'd16);
        chk("full_ready",  32'(bus.req_ready),  32'd0);
        grant_seen.delete();
        pl_hold = 1'b0;
        cycle();
        pl_hold = 1'b1;
        repeat (6) begin rand_data(); cycle(); end
        chk("full_one_grant", grant_seen.size(), 32'd1);
        quiesce();

        // drain with 6 in flight
        grant_seen.delete();
        pl_hold  = 1'b1;
        nx_valid = '1;
        repeat (6) begin rand_data(); cycle(); end
        chk("drain_issued", grant_seen.size(), 32'd6);
        nx_valid = '0; nx_drain = 1'b1; pl_hold = 1'b0;
        cycle();
        nx_drain = 1'b0; nx_valid = '1;
        grant_seen.delete(); rsp_seen.delete();
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            cycle();
            got = drain_done;
        end
        chk("drain_done_seen", 32'(got),          32'd1);
        chk("drain_rsp_count", rsp_seen.size(),   32'd6);
        chk("drain_no_grant",  grant_seen.size(), 32'd0);
        nx_drain = 1'b1;
        cycle();
        nx_drain = 1'b0;
        repeat (3) cycle();
        chk("halt_no_grant", grant_seen.size(), 32'd0);
        lastid    = m_last;
        nx_resume = 1'b1;
        cycle();
        nx_resume = 1'b0;
        cycle();
        chk("resume_grant", 32'(bus.req_ready), 32'd1 << ((lastid + 1) % N));
        quiesce();

        // result with an empty tag FIFO
        force_ready = 1'b1;
        cycle();
        force_ready = 1'b0;
        cycle();
        chk("uf_err", 32'(err_underflow),  32'd1);
        chk("uf_rsp", 32'(bus.rsp_valid),  32'd0);

        // randomized traffic with an asynchronous reset in the middle
        for (int it = 0; it < 300; it++) begin
            nx_valid  = N'($urandom);
            rand_data();
            nx_stall  = ($urandom_range(0, 99) < 15);
            nx_drain  = ($urandom_range(0, 99) < 2);
            nx_resume = ($urandom_range(0, 99) < 8);
            pl_hold   = ($urandom_range(0, 99) < 10);
            cycle();
            if (it == 150) begin
                nx_valid = '1;
                #2;
                rstn    = 1'b0;
                nx_rstn = 1'b0;
                #1;
                check_reset_values("arst");
                cycle();
                cycle();
                nx_rstn = 1'b1;
            end
        end
        nx_resume = 1'b1;
        cycle();
        quiesce();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
